sccb_slave_regfile: RTL
=======================

Name: sccb_slave_regfile

Overview:
- Synthesizable SCCB/I2C target: the responder side of the camera configuration bus, modelling the OV7670 register port.
- Oversamples SCL/SDA on the system clock and decodes START/STOP, device address, sub-address and data.
- Stores written bytes in an internal 256x8 register file and serves reads from it.
- Used as a loopback target for the configuration master on the DE1 board and as the bus responder in simulation benches.

Parameters:
- DEV_ADDR, 7'h21, 7-bit target address (write byte 0x42, read byte 0x43).
- FILTER_LEN, 3, consecutive equal samples needed before a filtered SCL/SDA level changes (1..7).

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST  in  1  synchronous reset, active-high
- iSCL  in  1  bus clock as seen at the pin
- iSDA  in  1  bus data as seen at the pin
- oSDA_OE  out  1  1 = pull SDA low, 0 = release (open-drain)
- oWR_STB  out  1  one-cycle pulse when a data byte is committed
- oWR_ADDR  out  8  register address of the committed byte
- oWR_DATA  out  8  committed byte
- iDBG_ADDR  in  8  debug read address
- oDBG_DATA  out  8  register file content at iDBG_ADDR, combinational
- oBUSY  out  1  1 from START until STOP

Behaviour:
- Input conditioning
  - iSCL and iSDA pass through a 2-FF synchronizer, then a glitch filter.
  - The filtered level toggles only after FILTER_LEN consecutive opposite samples.
  - Pin-to-filtered latency is 2+FILTER_LEN cycles.
- Bus events, evaluated on filtered signals
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge, MSB first.
  - oSDA_OE changes only on the SCL falling edge, in the cycle after detection.
- States: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE.
- IDLE -> DEV on START.
- DEV: shift 8 bits. On the 8th bit's SCL fall:
  - address match -> DEV_ACK (assert oSDA_OE);
  - mismatch -> IGNORE (never drive).
- DEV_ACK, on the SCL fall that ends the ACK slot:
  - R/W=0 -> REG, release SDA;
  - R/W=1 -> RDATA, drive bit7 of regfile[ptr] (oSDA_OE = ~bit).
- REG: 8 bits, then REG_ACK. Sub-address loads the pointer (ptr) when entering REG_ACK; REG_ACK -> WDATA.
- WDATA: 8 bits. On entering WDATA_ACK:
  - regfile[ptr] is written;
  - oWR_STB pulses for one cycle with oWR_ADDR=ptr and oWR_DATA=byte;
  - ptr increments modulo 256 (0xFF wraps to 0x00).
  - WDATA_ACK -> WDATA, allowing burst writes.
- RDATA: output 8 bits, then release SDA for MACK.
  - At the MACK rising edge, SDA=0 -> ptr+1 (wraps) and next byte in RDATA.
  - SDA=1 (NACK) -> IGNORE.
- Any START in any state, including repeated START, -> DEV with the bit counter cleared; ptr is kept.
- STOP in any state -> IDLE, oSDA_OE=0.
- A 2-phase write (dev, reg, STOP) only sets ptr; this is the SCCB read-setup sequence.
- Simultaneous events: START/STOP take priority over bit sampling in the same cycle; a SDA change while SCL is high is never sampled as data.
- Reset values:
  - oSDA_OE=0, oWR_STB=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0;
  - state=IDLE, ptr=0, filters preset to 1;
  - all regfile entries 0x00.
- Reset mid-transfer releases SDA in the next cycle; the target stays IDLE until a new START.
- The regfile has one write port (bus) and two read ports (bus, debug). oDBG_DATA reflects a write from the cycle after oWR_STB.

Test Plan:
- 3-phase write 0x42,0x12,0x80 at 100 kHz SCL -> ACK driven in all three ACK slots; exactly one oWR_STB with oWR_ADDR=0x12, oWR_DATA=0x80; oDBG_DATA(0x12)=0x80.
- Write 0x12=0x80, then 2-phase 0x42,0x12,STOP, then 0x43 and read 1 byte with NACK -> SDA carries 0x80 MSB-first; SDA released before STOP.
- Address 0x60 write -> oSDA_OE never asserted; no oWR_STB; oBUSY high until STOP.
- Burst write 0x42,0xFE,0x11,0x22,0x33 -> strobes at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33 (wrap).
- 1-cycle SDA glitch while SCL high, FILTER_LEN=3 -> no START/STOP detected; state unchanged.
- iRST asserted during the 5th bit of REG -> oSDA_OE=0 next cycle; the following full write 0x42,0x3A,0x04 completes normally with oWR_ADDR=0x3A.

Source files
------------

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C target with a 256x8 register file, modelling the OV7670 register port.
// SCL/SDA are synchronised and glitch-filtered on the system clock before any decoding.
module sccb_slave_regfile #(
  parameter logic [6:0]  DEV_ADDR   = 7'h21,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_OE,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  input  logic [7:0] iDBG_ADDR,
  output logic [7:0] oDBG_DATA,
  output logic       oBUSY
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StDev      = 4'd1;
  localparam logic [3:0] StDevAck   = 4'd2;
  localparam logic [3:0] StReg      = 4'd3;
  localparam logic [3:0] StRegAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StMack     = 4'd8;
  localparam logic [3:0] StIgnore   = 4'd9;

  localparam logic [2:0] FiltMax = 3'(FILTER_LEN - 1);

  // Bit 0 carries SCL, bit 1 carries SDA through the conditioning pipeline.
  logic [1:0] pin;
  logic [1:0] meta_q, sync_q, filt_q, prev_q;
  logic [2:0] fcnt_q [2];

  assign pin = {iSDA, iSCL};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      meta_q    <= '1;
      sync_q    <= '1;
      filt_q    <= '1;
      prev_q    <= '1;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FiltMax) begin
          filt_q[i] <= sync_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 3'd1;
        end
      end
    end
  end

  logic scl, sda, scl_rise, scl_fall, start_ev, stop_ev;
  assign scl      = filt_q[0];
  assign sda      = filt_q[1];
  assign scl_rise = scl & ~prev_q[0];
  assign scl_fall = ~scl & prev_q[0];
  assign start_ev = scl & prev_q[0] & prev_q[1] & ~sda;
  assign stop_ev  = scl & prev_q[0] & ~prev_q[1] & sda;

  logic [7:0] rf_q [256];

  // Bus writes land one cycle after the strobe, from the registered strobe outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < 256; i++) rf_q[i] <= '0;
    end else if (oWR_STB) begin
      rf_q[oWR_ADDR] <= oWR_DATA;
    end
  end

  assign oDBG_DATA = rf_q[iDBG_ADDR];

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] ptr_q, ptr_d, sh_q, sh_d, tx_q, tx_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic       oe_q, oe_d, stb_q, stb_d, mack_q, mack_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    oe_d      = oe_q;
    mack_d    = mack_q;
    stb_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_ev) begin
      state_d = StDev;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_ev) begin
      state_d = StIdle;
      oe_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StDev, StReg, StWdata: begin
          sh_d  = {sh_q[6:0], sda};
          cnt_d = cnt_q + 4'd1;
        end
        StRdata: cnt_d = cnt_q + 4'd1;
        StMack: begin
          if (!sda) begin
            ptr_d  = ptr_q + 8'd1;
            mack_d = 1'b1;
          end else begin
            state_d = StIgnore;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        StDev: begin
          if (cnt_q == 4'd8) begin
            if (sh_q[7:1] == DEV_ADDR) begin
              state_d = StDevAck;
              oe_d    = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StDevAck: begin
          cnt_d = '0;
          if (sh_q[0]) begin
            state_d = StRdata;
            tx_d    = rf_q[ptr_q];
            oe_d    = ~rf_q[ptr_q][7];
          end else begin
            state_d = StReg;
            oe_d    = 1'b0;
          end
        end
        StReg: begin
          if (cnt_q == 4'd8) begin
            state_d = StRegAck;
            ptr_d   = sh_q;
            oe_d    = 1'b1;
          end
        end
        StRegAck, StWdataAck: begin
          state_d = StWdata;
          cnt_d   = '0;
          oe_d    = 1'b0;
        end
        StWdata: begin
          if (cnt_q == 4'd8) begin
            state_d   = StWdataAck;
            stb_d     = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sh_q;
            ptr_d     = ptr_q + 8'd1;
            oe_d      = 1'b1;
          end
        end
        StRdata: begin
          if (cnt_q == 4'd8) begin
            state_d = StMack;
            cnt_d   = '0;
            mack_d  = 1'b0;
            oe_d    = 1'b0;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
            oe_d = ~tx_q[6];
          end
        end
        StMack: begin
          // Master acknowledged on the rising edge; present the next byte now.
          if (mack_q) begin
            state_d = StRdata;
            cnt_d   = '0;
            tx_d    = rf_q[ptr_q];
            oe_d    = ~rf_q[ptr_q][7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ptr_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      oe_q      <= 1'b0;
      mack_q    <= 1'b0;
      stb_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      oe_q      <= oe_d;
      mack_q    <= mack_d;
      stb_q     <= stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign oSDA_OE  = oe_q;
  assign oWR_STB  = stb_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oBUSY    = (state_q != StIdle);

endmodule
